// File: rtl/event_dispatcher_pkg.sv
// Shared types and widths for the event dispatcher and its FIFO.
package event_dispatcher_pkg;
  localparam int EVT_W = 32;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {IDLE, POST, WAIT_ACK, WAIT_DONE} disp_state_e;
endpackage

// File: rtl/event_fifo.sv
// Circular-buffer event FIFO with occupancy count; storage itself is not reset.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves occupancy unchanged
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/event_dispatcher.sv
// Queues incoming events and posts them one at a time to a CSR, waiting for
// the CSR receive counter to advance (with timeout) and then for processing.
module event_dispatcher
  import event_dispatcher_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [EVT_W-1:0]       io_in_type,
  input  logic                   io_has_event_rd,
  input  logic [CNT_W-1:0]       io_event_recv_cnt,
  input  logic [CNT_W-1:0]       io_event_processed_cnt,
  output logic                   io_has_event_wr,
  output logic [EVT_W-1:0]       io_event_type,
  output logic [$clog2(DEPTH):0] io_pending,
  output logic [CNT_W-1:0]       io_timeout_cnt,
  output logic                   io_err
);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  disp_state_e      state, state_nxt;
  logic [CNT_W-1:0] snap;
  logic [TW-1:0]    tmo;
  logic             full, empty, push, pop;
  logic [EVT_W-1:0] head;
  logic             csr_idle, acked, tmo_hit;

  assign io_in_ready     = !full;
  assign push            = io_in_valid && !full;
  assign csr_idle        = !io_has_event_rd && (io_event_recv_cnt == io_event_processed_cnt);
  assign acked           = io_event_recv_cnt != snap;
  assign tmo_hit         = tmo == TW'(ACK_TIMEOUT - 1);
  assign io_has_event_wr = state == POST;

  event_fifo #(.DEPTH(DEPTH), .W(EVT_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (io_in_type),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (io_pending)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:      if (!empty && csr_idle) begin
                   pop       = 1'b1;
                   state_nxt = POST;
                 end
      POST:      state_nxt = WAIT_ACK;
      WAIT_ACK:  if (acked)        state_nxt = WAIT_DONE;
                 else if (tmo_hit) state_nxt = IDLE;
      WAIT_DONE: if (csr_idle)     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      snap           <= '0;
      tmo            <= '0;
      io_event_type  <= '0;
      io_timeout_cnt <= '0;
      io_err         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        io_event_type <= head;
        snap          <= io_event_recv_cnt;
      end
      if (state == POST)          tmo <= '0;
      else if (state == WAIT_ACK) tmo <= tmo + 1'b1;
      // unacknowledged event is dropped; error stays set until reset
      if (state == WAIT_ACK && !acked && tmo_hit) begin
        io_timeout_cnt <= io_timeout_cnt + 1'b1;
        io_err         <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_event_dispatcher.sv
// Directed bench: CSR responder model plus scoreboard of expected posted types.
module tb_event_dispatcher;
  localparam int DEPTH = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        clock = 0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_type;
  logic        io_has_event_rd;
  logic [31:0] io_event_recv_cnt;
  logic [31:0] io_event_processed_cnt;
  logic        io_has_event_wr;
  logic [31:0] io_event_type;
  logic [$clog2(DEPTH):0] io_pending;
  logic [31:0] io_timeout_cnt;
  logic        io_err;

  event_dispatcher #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .io_in_valid            (io_in_valid),
    .io_in_ready            (io_in_ready),
    .io_in_type             (io_in_type),
    .io_has_event_rd        (io_has_event_rd),
    .io_event_recv_cnt      (io_event_recv_cnt),
    .io_event_processed_cnt (io_event_processed_cnt),
    .io_has_event_wr        (io_has_event_wr),
    .io_event_type          (io_event_type),
    .io_pending             (io_pending),
    .io_timeout_cnt         (io_timeout_cnt),
    .io_err                 (io_err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int n_hold = 10;
  bit ignore = 0;
  bit pend = 0;
  int hold = 0;
  int strobes = 0;
  int max_pend = 0;
  int acc_cnt = 0;
  int stall_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor + CSR responder, both on the falling edge so outputs are settled.
  always @(negedge clock) begin
    if (int'(io_pending) > max_pend) max_pend = int'(io_pending);
    if (io_has_event_wr === 1'b1) begin
      strobes++;
      chk("strobe_expected", 32'(exp_q.size() != 0), 1);
      chk("strobe_csr_idle", 32'(!io_has_event_rd && io_event_recv_cnt == io_event_processed_cnt), 1);
      if (exp_q.size() != 0) chk("strobe_type", io_event_type, exp_q.pop_front());
    end
    if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        io_event_processed_cnt = io_event_processed_cnt + 1;
        io_has_event_rd = 0;
      end
    end
    if (pend) begin
      pend = 0;
      io_event_recv_cnt = io_event_recv_cnt + 1;
      io_has_event_rd = 1;
      hold = n_hold;
    end
    if (io_has_event_wr === 1'b1 && !ignore) pend = 1;
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic push_evt(input logic [31:0] t);
    int w = 0;
    io_in_valid = 1;
    io_in_type  = t;
    if (!io_in_ready && stall_at < 0) begin
      stall_at = acc_cnt;
      chk("full_pending", 32'(io_pending), DEPTH);
    end
    while (!io_in_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    chk("push_accept_bound", 32'(w < 200), 1);
    exp_q.push_back(t);
    acc_cnt++;
    @(negedge clock);
    io_in_valid = 0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || io_has_event_rd || pend || hold != 0) && w < 800) begin
      @(negedge clock);
      w++;
    end
    repeat (2) @(negedge clock);
    chk("drain_bound", 32'(w < 800), 1);
    chk("drain_pending", 32'(io_pending), 0);
  endtask

  initial begin
    int s0;
    reset = 1;
    io_in_valid = 0;
    io_in_type = 0;
    io_has_event_rd = 0;
    io_event_recv_cnt = 0;
    io_event_processed_cnt = 0;
    #2;
    chk("rst_wr", 32'(io_has_event_wr), 0);
    chk("rst_type", io_event_type, 0);
    chk("rst_pending", 32'(io_pending), 0);
    chk("rst_tmo_cnt", io_timeout_cnt, 0);
    chk("rst_err", 32'(io_err), 0);
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_ready", 32'(io_in_ready), 1);

    // single event: strobe one cycle after the accept edge
    push_evt(32'h5);
    chk("single_no_early", 32'(io_has_event_wr), 0);
    @(negedge clock);
    chk("single_strobe", 32'(io_has_event_wr), 1);
    chk("single_type", io_event_type, 32'h5);
    wait_drain();

    // back-to-back
    max_pend = 0;
    s0 = strobes;
    push_evt(32'h1);
    push_evt(32'h2);
    push_evt(32'h3);
    wait_drain();
    chk("b2b_strobes", 32'(strobes - s0), 3);
    chk("b2b_peak", 32'(max_pend == 2 || max_pend == 3), 1);
    chk("b2b_last_type", io_event_type, 32'h3);

    // full: long CSR hold keeps the FIFO from draining
    n_hold = 40;
    acc_cnt = 0;
    stall_at = -1;
    s0 = strobes;
    for (int i = 0; i < DEPTH + 2; i++) push_evt(32'h10 + 32'(i));
    wait_drain();
    chk("full_stall_at", 32'(stall_at), DEPTH + 1);
    chk("full_strobes", 32'(strobes - s0), DEPTH + 2);
    n_hold = 10;

    // timeout: responder ignores the strobe
    ignore = 1;
    push_evt(32'hA);
    begin
      int w = 0;
      while (!io_has_event_wr && w < 20) begin
        @(negedge clock);
        w++;
      end
      chk("tmo_strobe_bound", 32'(w < 20), 1);
    end
    repeat (ACK_TIMEOUT) @(negedge clock);
    chk("tmo_err_early", 32'(io_err), 0);
    chk("tmo_cnt_early", io_timeout_cnt, 0);
    @(negedge clock);
    chk("tmo_err", 32'(io_err), 1);
    chk("tmo_cnt", io_timeout_cnt, 1);
    ignore = 0;
    s0 = strobes;
    push_evt(32'hB);
    wait_drain();
    chk("tmo_next_posted", 32'(strobes - s0), 1);
    chk("tmo_next_type", io_event_type, 32'hB);
    chk("tmo_cnt_hold", io_timeout_cnt, 1);

    // wrap: counter advance FFFFFFFF -> 0 counts as an ack
    io_event_recv_cnt = 32'hFFFF_FFFF;
    io_event_processed_cnt = 32'hFFFF_FFFF;
    @(negedge clock);
    push_evt(32'hC);
    wait_drain();
    chk("wrap_recv", io_event_recv_cnt, 0);
    chk("wrap_no_tmo", io_timeout_cnt, 1);
    chk("wrap_type", io_event_type, 32'hC);

    // reset during WAIT_ACK with two events still queued
    ignore = 1;
    push_evt(32'h21);
    push_evt(32'h22);
    push_evt(32'h23);
    repeat (3) @(negedge clock);
    chk("mid_pending", 32'(io_pending), 2);
    #2 reset = 1;
    #1;
    chk("mid_rst_wr", 32'(io_has_event_wr), 0);
    chk("mid_rst_type", io_event_type, 0);
    chk("mid_rst_pending", 32'(io_pending), 0);
    chk("mid_rst_tmo_cnt", io_timeout_cnt, 0);
    chk("mid_rst_err", 32'(io_err), 0);
    exp_q.delete();
    @(negedge clock);
    reset = 0;
    s0 = strobes;
    repeat (30) @(negedge clock);
    chk("mid_no_strobe", 32'(strobes - s0), 0);
    chk("mid_ready", 32'(io_in_ready), 1);
    ignore = 0;
    push_evt(32'h33);
    wait_drain();
    chk("mid_new_strobe", 32'(strobes - s0), 1);
    chk("mid_new_type", io_event_type, 32'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/event_dispatcher.md
EVENT_DISPATCHER -- requirements
Module: event_dispatcher

Interface
REQ-001 The module SHALL expose these parameters (name, default, meaning):
- DEPTH, 4, event FIFO entries, power of two, at least 2.
- ACK_TIMEOUT, 16, cycles to wait for the receive counter to advance.
REQ-002 The module SHALL expose these ports (name, direction, width, meaning):
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- io_in_valid, in, 1: producer offers an event.
- io_in_ready, out, 1: FIFO can accept.
- io_in_type, in, 32: event type code.
- io_has_event_rd, in, 1: CSR event-pending flag.
- io_event_recv_cnt, in, 32: CSR received-event counter.
- io_event_processed_cnt, in, 32: CSR processed-event counter.
- io_has_event_wr, out, 1: one-cycle post strobe to CSR.
- io_event_type, out, 32: type of the posted event.
- io_pending, out, log2(DEPTH)+1: FIFO occupancy.
- io_timeout_cnt, out, 32: events dropped on ack timeout.
- io_err, out, 1: sticky timeout flag.

Function
REQ-003 Input handshake: an event SHALL be accepted on a cycle with io_in_valid && io_in_ready.
REQ-004 io_in_ready SHALL equal "FIFO not full", evaluated before any same-cycle pop. There is no full-bypass.
REQ-005 Every event SHALL pass through the FIFO. There is no empty-bypass.
- Minimum latency from accept edge to io_has_event_wr high: 1 cycle.
REQ-006 The FSM SHALL have four states: IDLE, POST, WAIT_ACK, WAIT_DONE.
REQ-007 IDLE to POST SHALL occur when all three hold:
- FIFO not empty;
- io_has_event_rd == 0;
- io_event_recv_cnt == io_event_processed_cnt.
REQ-008 On the IDLE to POST transition the FSM SHALL pop the FIFO head into the io_event_type register and snapshot io_event_recv_cnt.
REQ-009 POST SHALL drive io_has_event_wr=1 for exactly one cycle, then go to WAIT_ACK.
REQ-010 In WAIT_ACK, when io_event_recv_cnt != snapshot (a 32-bit equality test, so wrap-safe), the FSM SHALL go to WAIT_DONE.
REQ-011 In WAIT_ACK, after ACK_TIMEOUT cycles without the counter advancing, the FSM SHALL:
- increment io_timeout_cnt (wraps modulo 2^32);
- set io_err;
- return to IDLE; the event is dropped.
REQ-012 WAIT_DONE SHALL go to IDLE when io_has_event_rd == 0 and io_event_recv_cnt == io_event_processed_cnt.
- WAIT_DONE has no timeout.
REQ-013 io_event_type SHALL hold the last posted value until the next POST.
REQ-014 io_pending SHALL reflect pushes and pops registered at the prior edge.
- A simultaneous push and pop leaves it unchanged.
REQ-015 io_err SHALL be cleared only by reset.

Reset
REQ-016 Asserting reset SHALL act immediately, regardless of clock:
- FSM to IDLE;
- FIFO emptied;
- io_has_event_wr=0, io_event_type=0, io_pending=0, io_timeout_cnt=0, io_err=0;
- io_in_ready=1 once reset is released.
REQ-017 Reset asserted mid-POST or mid-WAIT SHALL discard the in-flight event and all queued events.
- No strobe SHALL be emitted after reset is released until a new event is accepted.

Structure
REQ-018 A shared package SHALL hold:
- the FSM state enum;
- the event width constant (32);
- the counter width constant (32).
REQ-019 The FIFO SHALL be a sub-module event_fifo with:
- push/pop/full/empty/count ports;
- parameter DEPTH;
- the same clock and asynchronous reset.
REQ-020 The timeout counter and the snapshot register SHALL live in event_dispatcher.

Verification
REQ-021 The bench SHALL model the CSR as a responder: on io_has_event_wr it increments recv_cnt next cycle, holds has_event_rd=1 for N cycles, then increments processed_cnt and clears has_event_rd.
REQ-022 Single event: push type 0x5 with CSR idle.
- Strobe 1 cycle after accept, io_event_type=0x5.
- Back in IDLE after the responder finishes.
REQ-023 Back-to-back: push 0x1, 0x2, 0x3 on consecutive cycles with N=10.
- Three strobes in order 1, 2, 3.
- Each strobe only after processed_cnt == recv_cnt.
- io_pending peaks at 2 or 3.
REQ-024 Full: stall the responder and push DEPTH+2 events.
- io_in_ready drops after DEPTH entries plus the one popped.
- No event is lost or reordered.
REQ-025 Timeout: the responder ignores the strobe.
- After 16 cycles in WAIT_ACK: io_timeout_cnt=1, io_err=1, next event is posted normally.
REQ-026 Wrap: preset recv_cnt = processed_cnt = 0xFFFFFFFF.
- An ack to 0x00000000 is detected; no timeout.
REQ-027 Reset mid-WAIT_ACK with 2 events queued.
- All outputs return to reset values.
- No strobe until a new push.
